// File: rtl/add_channel_sched.sv
// add_channel_sched: sums NUM_CH channel samples per pixel with one adder
// and sequences a full D x D frame (start / busy / frame_done).
//
// Ports:
//   clk, reset   rising-edge clock, async active-high reset
//   start        one-cycle pulse, begins a frame and samples num_ch
//   num_ch       channels per pixel (0 is treated as 1)
//   valid_in     pxl_in carries a channel sample this cycle
//   pxl_in       channel sample, pixel-major / channel-minor order
//   pxl_out      per-pixel channel sum, held between pulses
//   valid_out    one-cycle pulse per completed pixel
//   busy         high while a frame is being accumulated
//   frame_done   pulse coincident with the last pixel's valid_out
module add_channel_sched #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32,
    parameter int CH_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CH_W-1:0]       num_ch,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int NPIX  = D * D;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CH_W-1:0]       nch;
    logic [CH_W-1:0]       ch_cnt;
    logic [PIX_W-1:0]      pix_cnt;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] sum;
    logic                  take;
    logic                  last_ch;
    logic                  last_pix;

    // Samples only count while a frame is running.
    assign take     = (state == RUN) && valid_in;
    assign last_ch  = (ch_cnt == nch - CH_W'(1));
    assign last_pix = (pix_cnt == PIX_W'(NPIX - 1));

    // Channel 0 restarts the sum so no stale accumulator leaks in.
    assign sum = (ch_cnt == '0) ? pxl_in : acc + pxl_in;

    assign busy = (state == RUN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (take && last_ch && last_pix) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nch        <= '0;
            ch_cnt     <= '0;
            pix_cnt    <= '0;
            acc        <= '0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            if (state == IDLE && start) begin
                nch     <= (num_ch == '0) ? CH_W'(1) : num_ch;
                ch_cnt  <= '0;
                pix_cnt <= '0;
            end
            if (take) begin
                acc <= sum;
                if (last_ch) begin
                    pxl_out    <= sum;
                    valid_out  <= 1'b1;
                    frame_done <= last_pix;
                    ch_cnt     <= '0;
                    pix_cnt    <= pix_cnt + PIX_W'(1);
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_add_channel_sched.sv
// Testbench for add_channel_sched: directed frames with random data/gaps,
// checked every cycle against a queue-based reference model.
module tb_add_channel_sched;

    localparam int D    = 2;
    localparam int DW   = 32;
    localparam int CHW  = 4;
    localparam int NPIX = D * D;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CHW-1:0] num_ch;
    logic          valid_in;
    logic [DW-1:0] pxl_in;
    logic [DW-1:0] pxl_out;
    logic          valid_out;
    logic          busy;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 idle, 1 running, 2 finishing
    int            m_phase;
    int            m_nch;
    int            m_pix;
    logic [DW-1:0] chq[$];
    logic [DW-1:0] exp_out;
    logic          exp_valid;
    logic          exp_done;
    logic          exp_busy;
    int            vo_cnt;
    int            fd_cnt;

    always #5 clk = ~clk;

    add_channel_sched #(
        .D(D),
        .DATA_WIDTH(DW),
        .CH_W(CHW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_ch(num_ch),
        .valid_in(valid_in),
        .pxl_in(pxl_in),
        .pxl_out(pxl_out),
        .valid_out(valid_out),
        .busy(busy),
        .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_nch     = 1;
        m_pix     = 0;
        chq.delete();
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_busy  = 1'b0;
    endtask

    // What the block should show after a clock edge that sampled these inputs.
    task automatic model_edge(input logic s, input logic [CHW-1:0] n,
                              input logic v, input logic [DW-1:0] d);
        logic [DW-1:0] tot;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_nch   = (n == 0) ? 1 : int'(n);
                m_pix   = 0;
                chq.delete();
            end
        end else if (m_phase == 1) begin
            if (v) begin
                chq.push_back(d);
                if (chq.size() == m_nch) begin
                    tot = '0;
                    foreach (chq[i]) tot += chq[i];
                    chq.delete();
                    exp_out   = tot;
                    exp_valid = 1'b1;
                    m_pix++;
                    if (m_pix == NPIX) begin
                        exp_done = 1'b1;
                        m_phase  = 2;
                    end
                end
            end
        end else begin
            m_phase = 0;
        end
        exp_busy = (m_phase == 1);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid_out"}, DW'(valid_out), DW'(exp_valid));
        chk({tag, ".frame_done"}, DW'(frame_done), DW'(exp_done));
        chk({tag, ".busy"}, DW'(busy), DW'(exp_busy));
        chk({tag, ".pxl_out"}, pxl_out, exp_out);
    endtask

    // One clock: drive at edge+1, sample at the next edge+1.
    task automatic step(input string tag, input logic s,
                        input logic [CHW-1:0] n, input logic v,
                        input logic [DW-1:0] d);
        start    = s;
        num_ch   = n;
        valid_in = v;
        pxl_in   = d;
        @(posedge clk);
        #1;
        model_edge(s, n, v, d);
        if (valid_out) vo_cnt++;
        if (frame_done) fd_cnt++;
        check_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, ".n_valid"}, DW'(vo_cnt), DW'(NPIX));
        chk({tag, ".n_done"}, DW'(fd_cnt), 32'd1);
        vo_cnt = 0;
        fd_cnt = 0;
    endtask

    initial begin
        logic [DW-1:0] d;
        int            k;

        reset    = 1'b1;
        start    = 1'b0;
        num_ch   = '0;
        valid_in = 1'b0;
        pxl_in   = '0;
        vo_cnt   = 0;
        fd_cnt   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        reset = 1'b0;

        // 1: three channels, back to back, p*10+c
        idle("t1", 1);
        step("t1", 1'b1, 4'd3, 1'b0, '0);
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < 3; c++)
                step("t1", 1'b0, 4'd9, 1'b1, DW'(10 * p + c));
        idle("t1", 2);
        frame_counts("t1");

        // 2: num_ch=0 acts as one channel; trailing samples in idle dropped
        step("t2", 1'b1, 4'd0, 1'b0, '0);
        for (int i = 0; i < NPIX; i++)
            step("t2", 1'b0, 4'd0, 1'b1, DW'(5 + i));
        for (int i = 0; i < 3; i++)
            step("t2", 1'b0, 4'd0, 1'b1, $urandom);
        frame_counts("t2");

        // 3: two channels with random gaps, 0x7FFFFFFF + 1 wraps
        step("t3", 1'b1, 4'd2, 1'b0, '0);
        k = 0;
        while (k < 2 * NPIX) begin
            if ($urandom_range(0, 2) == 0) begin
                step("t3", 1'b0, 4'd7, 1'b0, $urandom);
            end else begin
                d = (k % 2 == 0) ? 32'h7FFF_FFFF : 32'h1;
                step("t3", 1'b0, 4'd7, 1'b1, d);
                k++;
            end
        end
        chk("t3.wrap", exp_out, 32'h8000_0000);
        idle("t3", 2);
        frame_counts("t3");

        // 4: reset mid-frame, then a clean frame
        step("t4", 1'b1, 4'd2, 1'b0, '0);
        for (int i = 0; i < 5; i++)
            step("t4", 1'b0, 4'd2, 1'b1, $urandom);
        reset = 1'b1;
        #1;
        model_reset();
        check_outs("t4.rst");
        @(posedge clk);
        #1;
        check_outs("t4.rst_hold");
        reset  = 1'b0;
        vo_cnt = 0;
        fd_cnt = 0;
        step("t4b", 1'b1, 4'd2, 1'b0, '0);
        for (int i = 0; i < 2 * NPIX; i++)
            step("t4b", 1'b0, 4'd2, 1'b1, $urandom);
        idle("t4b", 2);
        frame_counts("t4b");

        // 5: idle samples, start+valid together, start mid-run
        for (int i = 0; i < 3; i++)
            step("t5", 1'b0, 4'd3, 1'b1, $urandom);
        step("t5", 1'b1, 4'd2, 1'b1, 32'd99);
        for (int i = 0; i < 2 * NPIX; i++)
            step("t5", (i == 3), 4'd5, 1'b1, $urandom);
        idle("t5", 2);
        frame_counts("t5");

        // 6: fifteen channels of -1 gives -15 per pixel
        step("t6", 1'b1, 4'd15, 1'b0, '0);
        for (int i = 0; i < 15 * NPIX; i++)
            step("t6", 1'b0, 4'd15, 1'b1, 32'hFFFF_FFFF);
        chk("t6.sum", pxl_out, 32'hFFFF_FFF1);
        idle("t6", 2);
        frame_counts("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_channel_sched.md
Name: add_channel_sched

Overview:
- Time-multiplexes one two-input adder to sum NUM_CH channel feature maps pixel-by-pixel into one output map.
- Sits after the conv-layer channel outputs, in place of a cascade of chained two-input add stages, when channels arrive channel-interleaved on one stream.
- Sequences a full D×D frame: per-pixel channel counter, frame pixel counter, start/busy/done handshake.

Parameters:
- D, 220, feature-map side length; frame = D*D pixels.
- DATA_WIDTH, 32, pixel/sum width, two's complement.
- CH_W, 4, width of channel-count config port; max channels 2^CH_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a frame, samples num_ch.
- num_ch  in  CH_W  channels per pixel; 0 is treated as 1.
- valid_in  in  1  pxl_in is valid this cycle.
- pxl_in  in  DATA_WIDTH  channel sample; order is pixel p ch0..ch(N-1), then pixel p+1.
- pxl_out  out  DATA_WIDTH  channel sum for one pixel.
- valid_out  out  1  pxl_out valid, one-cycle pulse per pixel.
- busy  out  1  high while the frame is in progress.
- frame_done  out  1  one-cycle pulse coincident with the last pixel's valid_out.

Behaviour:
- Reset values: pxl_out=0, valid_out=0, busy=0, frame_done=0, state=IDLE, all counters=0, accumulator=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - valid_in is ignored.
  - start=1 latches nch = (num_ch==0 ? 1 : num_ch), clears ch_cnt and pix_cnt, and moves to RUN.
  - busy=1 from the cycle after start.
- RUN, on valid_in=1:
  - ch_cnt==0: acc <= pxl_in.
  - Otherwise: acc <= acc + pxl_in, truncated to DATA_WIDTH (modulo wrap, no saturation).
  - ch_cnt==nch-1: pxl_out <= (ch_cnt==0 ? pxl_in : acc+pxl_in), valid_out<=1 next cycle, ch_cnt<=0, pix_cnt++.
  - Otherwise: ch_cnt++.
  - valid_in=0 holds all state. Gaps are allowed anywhere, including mid-pixel.
- Latency: exactly 1 cycle from the last channel's valid_in to valid_out. Throughput is 1 sample/cycle, with no stall output.
- Last pixel (pix_cnt==D*D-1 on its final channel):
  - frame_done=1 in the same cycle as that valid_out.
  - state -> DONE; busy drops to 0 in that same cycle.
- DONE: lasts one cycle, then IDLE. valid_in is ignored.
- start while in RUN or DONE is ignored. num_ch changes after start have no effect until the next start.
- start and valid_in in the same IDLE cycle: the sample is ignored; the first accepted sample is on the next cycle.
- valid_in after the frame completes (in IDLE) is dropped; no output is generated.
- reset asserted mid-frame: immediate return to reset values. The partial pixel is discarded, with no valid_out and no frame_done.
- pxl_out holds its last value between valid_out pulses.

Test Plan (bench overrides D=2, DATA_WIDTH=32):
1. Reset, start with num_ch=3, feed 12 back-to-back samples, pixel p channel c = 10*p+c -> valid_out at 4 pixels with sums 3, 33, 63, 93; each sum 1 cycle after the 3rd channel; frame_done with the 93; busy low after.
2. num_ch=0, feed 4 samples 5, 6, 7, 8 -> treated as 1 channel; outputs 5, 6, 7, 8, each 1 cycle after input; frame_done with 8.
3. num_ch=2 with random valid_in gaps (including between ch0 and ch1), samples 0x7FFFFFFF+1 per pixel -> sum wraps to 0x80000000 on every pixel; output count is exactly 4.
4. Reset asserted after 5 samples of a num_ch=2 frame -> all outputs 0 immediately. A new start with a clean 8-sample frame then produces correct sums with no stale accumulator.
5. valid_in pulses before any start, and a start pulse mid-RUN -> samples ignored, frame unaffected, exactly 4 valid_out and one frame_done.
6. num_ch=15, sample values -1 for all channels -> each sum = -15 (0xFFFFFFF1); frame_done after pixel 4.
